// File: rtl/ocm_stream_reader.sv
// Avalon-MM read master that streams a window of on-chip memory words onto a
// valid/ready interface. Reads are issued against a credit that reserves FIFO
// space for every read in flight, so returning data always has a slot.
module ocm_stream_reader #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_num_words,
  output logic [ADDR_W-1:0] o_m_address,
  output logic              o_m_chipselect,
  output logic              o_m_write,
  output logic [3:0]        o_m_byteenable,
  output logic              o_m_clken,
  input  logic [DATA_W-1:0] i_m_readdata,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DepthL = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_e;

  state_e                  r_state, w_state_d;
  logic [ADDR_W-1:0]       r_addr;
  logic [ADDR_W:0]         r_num;
  logic [ADDR_W:0]         r_issue_cnt;
  logic [ADDR_W:0]         r_accept_cnt;
  logic [READ_LATENCY-1:0] r_sr, w_sr_d;
  logic [CNT_W-1:0]        r_inflight;
  logic [CNT_W-1:0]        r_count;
  logic [PTR_W-1:0]        r_wptr, r_rptr;
  logic [DATA_W-1:0]       r_fifo [FIFO_DEPTH];

  logic                    w_issue;
  logic                    w_ret;
  logic                    w_pop;
  logic                    w_accept_start;
  logic [CNT_W:0]          w_occ;

  assign o_m_write      = 1'b0;
  assign o_m_byteenable = 4'hF;
  assign o_m_clken      = 1'b1;
  assign o_m_address    = r_addr;

  // Issue credit, FIFO head presentation and in-flight shift next-state.
  always_comb begin
    w_occ          = {1'b0, r_count} + {1'b0, r_inflight};
    w_issue        = (r_state == StIssue) && (r_issue_cnt != r_num) && (w_occ < DepthL);
    w_ret          = r_sr[READ_LATENCY-1];
    o_out_valid    = (r_count != '0);
    o_out_data     = o_out_valid ? r_fifo[r_rptr] : '0;
    w_pop          = o_out_valid & i_out_ready;
    w_accept_start = (r_state == StIdle) & i_start;
    w_sr_d         = '0;
    w_sr_d[0]      = w_issue;
    for (int i = 1; i < int'(READ_LATENCY); i++) begin
      w_sr_d[i] = r_sr[i-1];
    end
  end

  // Transfer sequencing and status outputs.
  always_comb begin
    w_state_d      = r_state;
    o_m_chipselect = w_issue;
    o_busy         = (r_state != StIdle);
    o_done         = (r_state == StFin);
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = (i_num_words == '0) ? StFin : StIssue;
        end
      end
      StIssue: begin
        if (w_issue && ((r_issue_cnt + (ADDR_W + 1)'(1)) == r_num)) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if ((r_inflight == '0) && (r_count == '0) && (r_accept_cnt == r_num)) begin
          w_state_d = StFin;
        end
      end
      StFin: begin
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Control state, counters, in-flight tracking and FIFO pointers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_num        <= '0;
      r_issue_cnt  <= '0;
      r_accept_cnt <= '0;
      r_sr         <= '0;
      r_inflight   <= '0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept_start) begin
        r_addr       <= i_base_addr;
        r_num        <= i_num_words;
        r_issue_cnt  <= '0;
        r_accept_cnt <= '0;
      end else begin
        if (w_issue) begin
          // Natural wrap of the ADDR_W-bit address covers 1023 -> 0.
          r_addr      <= r_addr + ADDR_W'(1);
          r_issue_cnt <= r_issue_cnt + (ADDR_W + 1)'(1);
        end
        if (w_pop) begin
          r_accept_cnt <= r_accept_cnt + (ADDR_W + 1)'(1);
        end
      end
      r_sr       <= w_sr_d;
      r_inflight <= r_inflight + CNT_W'(w_issue) - CNT_W'(w_ret);
      r_count    <= r_count + CNT_W'(w_ret) - CNT_W'(w_pop);
      if (w_ret) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge i_clk) begin
    if (w_ret) begin
      r_fifo[r_wptr] <= i_m_readdata;
    end
  end

endmodule

// File: tb/tb_ocm_stream_reader.sv
// Scoreboard bench for ocm_stream_reader with a 1-cycle-latency memory model.
module tb_ocm_stream_reader;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic [AW-1:0] m_addr;
  logic          m_cs;
  logic          m_write;
  logic [3:0]    m_be;
  logic          m_clken;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ocm_stream_reader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .READ_LATENCY(1),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_base_addr   (base_addr),
    .i_num_words   (num_words),
    .o_m_address   (m_addr),
    .o_m_chipselect(m_cs),
    .o_m_write     (m_write),
    .o_m_byteenable(m_be),
    .o_m_clken     (m_clken),
    .i_m_readdata  (m_rdata),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_busy        (busy),
    .o_done        (done)
  );

  logic [DW-1:0] mem [1024];
  initial m_rdata = '0;
  always @(posedge clk) if (m_cs) m_rdata <= mem[m_addr];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] data_q[$];
  logic [AW-1:0] addr_q[$];
  int done_cnt = 0, cs_cnt = 0, vld_rise = 0, stall_cnt = 0;
  int acc_cnt = 0, acc_first = 0, acc_last = 0, first_cs = -1, first_vld = -1;
  logic prev_stall = 1'b0;
  logic prev_vld = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: checks issued addresses and accepted words against the queues.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (rst) begin
      prev_stall = 1'b0;
      prev_vld   = 1'b0;
    end else begin
      if (m_cs) begin
        cs_cnt++;
        if (first_cs < 0) first_cs = cyc;
        if (addr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL addr_extra: got issue at 0x%0h, expected no issue", m_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("addr", 32'(m_addr), 32'(ea));
        end
      end
      if (busy && !m_cs && addr_q.size() > 0) stall_cnt++;
      if (out_valid && !prev_vld) begin
        vld_rise++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (data_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL data_extra: got word 0x%0h, expected none", out_data);
        end else begin
          ed = data_q.pop_front();
          chk("data", out_data, ed);
        end
        if (acc_cnt == 0) acc_first = cyc;
        acc_last = cyc;
        acc_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_vld   = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    for (int k = 0; k < int'(n); k++) begin
      logic [AW-1:0] a;
      a = b + AW'(k);
      addr_q.push_back(a);
      data_q.push_back(mem[a]);
    end
    start = 1'b1; base_addr = b; num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input bit toggle);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (toggle) out_ready = ~out_ready;
      tick();
      if (done_cnt > d0) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: got no done, expected done within 2000 cycles");
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_cs"}, 32'(m_cs), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, out_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0, c0, v0;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
    repeat (3) tick();
    chk_reset_outputs("rst");
    chk("tie_write", 32'(m_write), 32'd0);
    chk("tie_be", 32'(m_be), 32'hF);
    chk("tie_clken", 32'(m_clken), 32'd1);
    rst = 1'b0;
    tick();

    // 1: basic 4-word window at full throughput
    acc_cnt = 0; first_cs = -1; first_vld = -1; d0 = done_cnt;
    do_start(10'h010, 11'd4);
    wait_done(1'b0);
    chk("t1_words", 32'(acc_cnt), 32'd4);
    chk("t1_consec", 32'(acc_last - acc_first), 32'd3);
    chk("t1_latency", 32'(first_vld - first_cs), 32'd2);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
    tick();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_done_low", 32'(done), 32'd0);

    // 2: address wrap 0x3FE -> 0x001
    acc_cnt = 0;
    do_start(10'h3FE, 11'd4);
    wait_done(1'b0);
    chk("t2_words", 32'(acc_cnt), 32'd4);
    tick();

    // 3: 16 words with out_ready toggling every cycle
    acc_cnt = 0; stall_cnt = 0;
    do_start(10'h020, 11'd16);
    wait_done(1'b1);
    out_ready = 1'b1;
    chk("t3_words", 32'(acc_cnt), 32'd16);
    chk("t3_cs_stalled", 32'(stall_cnt != 0), 32'd1);
    tick();

    // 4: zero-length transfer
    c0 = cs_cnt; v0 = vld_rise; d0 = done_cnt;
    do_start(10'h100, 11'd0);
    chk("t4_done_now", 32'(done), 32'd1);
    tick();
    chk("t4_done_pulse", 32'(done), 32'd0);
    repeat (3) tick();
    chk("t4_no_cs", 32'(cs_cnt - c0), 32'd0);
    chk("t4_no_valid", 32'(vld_rise - v0), 32'd0);
    chk("t4_done_once", 32'(done_cnt - d0), 32'd1);

    // 5: start while busy is ignored
    acc_cnt = 0;
    do_start(10'h050, 11'd8);
    tick();
    start = 1'b1; base_addr = 10'h300; num_words = 11'd5;
    tick();
    start = 1'b0;
    wait_done(1'b0);
    chk("t5_words", 32'(acc_cnt), 32'd8);
    repeat (3) tick();
    chk("t5_idle", 32'(busy), 32'd0);

    // 6: reset mid-transfer with data buffered and reads in flight
    out_ready = 1'b0;
    do_start(10'h200, 11'd16);
    repeat (3) tick();
    rst = 1'b1;
    data_q.delete();
    addr_q.delete();
    tick();
    chk_reset_outputs("t6");
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t6_no_stale", 32'(out_valid), 32'd0);
    acc_cnt = 0;
    do_start(10'h005, 11'd3);
    wait_done(1'b0);
    chk("t6_words", 32'(acc_cnt), 32'd3);
    tick();

    chk("queues_empty", 32'(data_q.size() + addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
